alu_exec_unit: RTL and testbench
================================

# alu_exec_unit

Execute-stage arithmetic block of the single-cycle MIPS datapath. Combines three functions:
- ALU-control decode from the main-control `aluop` and the R-type `func` field.
- 32-bit ALU with zero detection; the zero flag feeds branch selection.
- PC+4 incrementer.

The datapath paths (`aluctrl`, `result`, `zero`, `ovf`, `pc_plus4`) are purely combinational so that DM, write-back and next-PC logic settle within the same cycle. A registered copy of the ALU status is kept for debug and for future pipelining.

## Interface
Parameters:
- `WIDTH`, 32: datapath width. Only 32 is required to be supported.

Ports:
- `clk`  input  1  clock. Registered copies update on the rising edge.
- `rst`  input  1  reset, asynchronous, active-low.
- `in1`  input  32  operand A (rs data).
- `in2`  input  32  operand B (rt data or sign-extended immediate).
- `func`  input  6  instruction bits [5:0].
- `aluop`  input  2  ALU operation class from the control unit.
- `pc`  input  32  current PC.
- `aluctrl`  output  4  decoded ALU control. Combinational.
- `result`  output  32  ALU result. Combinational.
- `zero`  output  1  1 when `result` == 0. Combinational.
- `ovf`  output  1  signed overflow of ADD/SUB. Combinational, informational only, never traps.
- `pc_plus4`  output  32  `pc` + 4. Combinational.
- `result_q`  output  32  `result` registered.
- `zero_q`  output  1  `zero` registered.
- `ovf_q`  output  1  `ovf` registered.

## Operation
ALU-control decode (`aluctrl`):
- `aluop` 00 → 0010 (ADD; lw/sw address calculation).
- `aluop` 01 → 0110 (SUB; beq).
- `aluop` 11 → 0001 (OR; ori).
- `aluop` 10 → decode `func`:
  - 100000 → 0010 (add)
  - 100010 → 0110 (sub)
  - 100100 → 0000 (and)
  - 100101 → 0001 (or)
  - 100111 → 1100 (nor)
  - 101010 → 0111 (slt)
  - any other `func` → 0010 (add)

ALU function by `aluctrl`:
- 0000: `in1` & `in2`.
- 0001: `in1` | `in2`.
- 0010: `in1` + `in2`, modulo 2^32.
- 0110: `in1` − `in2`, modulo 2^32.
- 0111: 32'd1 if `in1` < `in2` as signed two's complement, else 32'd0. Computed by signed comparison, not from the subtraction sign bit, so it is correct on overflow.
- 1100: ~(`in1` | `in2`).
- Any other code: `result` = 0, so `zero` = 1.

Flags:
- `zero` = (`result` == 0) for every operation, including SLT and the logical operations.
- `ovf` is set for ADD when both operands have the same sign and the result sign differs.
- `ovf` is set for SUB when the operand signs differ and the result sign differs from `in1`.
- `ovf` = 0 for all other operations.

PC incrementer:
- `pc_plus4` = `pc` + 32'd4, modulo 2^32. FFFF_FFFC wraps to 0000_0000.
- The low two bits of `pc` pass through unchecked.

## Timing
- All datapath outputs are combinational with zero latency. No clock is required for them.
- `result_q`, `zero_q`, `ovf_q` capture `result`, `zero`, `ovf` on each rising `clk`, giving a 1-cycle latency.
- `rst` low asynchronously forces `result_q` = 0, `zero_q` = 0, `ovf_q` = 0, independent of `clk`.
- The registers stay at their reset values while `rst` is low.
- Capture resumes at the first rising edge after `rst` goes high.
- Reset asserted mid-operation has no effect on the combinational outputs.
- No handshake. Inputs may change every cycle.

## Test plan
- `aluop`=10 with each listed `func` → `aluctrl` 0010/0110/0000/0001/1100/0111. `func`=000000 → 0010. `aluop`=00/01/11 → 0010/0110/0001 for any `func`.
- ADD 7FFF_FFFF + 1 → `result` 8000_0000, `ovf`=1, `zero`=0. ADD FFFF_FFFF + 1 → `result` 0, `zero`=1, `ovf`=0.
- SUB (`aluop`=01) 5 − 5 → `result` 0, `zero`=1. SUB 8000_0000 − 1 → `result` 7FFF_FFFF, `ovf`=1.
- SLT FFFF_FFFF vs 1 → `result` 1. SLT 1 vs FFFF_FFFF → `result` 0, `zero`=1. SLT 8000_0000 vs 7FFF_FFFF → `result` 1.
- `pc` = 0000_3000 → `pc_plus4` = 0000_3004. `pc` = FFFF_FFFC → 0000_0000.
- Drive ADD 2+3, clock once → `result_q`=5, `zero_q`=0. Then pull `rst` low between edges → `result_q`=0 immediately, and it stays 0 across edges until `rst` goes high.

Source files
------------

// File: rtl/alu_exec_unit.sv
// MIPS execute stage: ALU-control decode, 32-bit ALU with zero/overflow flags, PC+4 incrementer.
// Datapath outputs are combinational; the ALU status copy is registered with 1-cycle latency; there is no handshake.
module alu_exec_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] in1,
  input  logic [WIDTH-1:0] in2,
  input  logic [5:0]       func,
  input  logic [1:0]       aluop,
  input  logic [WIDTH-1:0] pc,
  output logic [3:0]       aluctrl,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             ovf,
  output logic [WIDTH-1:0] pc_plus4,
  output logic [WIDTH-1:0] result_q,
  output logic             zero_q,
  output logic             ovf_q
);

  localparam logic [3:0] CTRL_AND = 4'b0000;
  localparam logic [3:0] CTRL_OR  = 4'b0001;
  localparam logic [3:0] CTRL_ADD = 4'b0010;
  localparam logic [3:0] CTRL_SUB = 4'b0110;
  localparam logic [3:0] CTRL_SLT = 4'b0111;
  localparam logic [3:0] CTRL_NOR = 4'b1100;

  logic [WIDTH-1:0] sum;
  logic [WIDTH-1:0] diff;
  logic             sum_ovf;
  logic             diff_ovf;

  always_comb begin
    aluctrl = CTRL_ADD;
    case (aluop)
      2'b00: aluctrl = CTRL_ADD;
      2'b01: aluctrl = CTRL_SUB;
      2'b11: aluctrl = CTRL_OR;
      default: begin
        case (func)
          6'b100000: aluctrl = CTRL_ADD;
          6'b100010: aluctrl = CTRL_SUB;
          6'b100100: aluctrl = CTRL_AND;
          6'b100101: aluctrl = CTRL_OR;
          6'b100111: aluctrl = CTRL_NOR;
          6'b101010: aluctrl = CTRL_SLT;
          default:   aluctrl = CTRL_ADD;
        endcase
      end
    endcase
  end

  assign sum  = in1 + in2;
  assign diff = in1 - in2;
  assign sum_ovf  = (in1[WIDTH-1] == in2[WIDTH-1]) && (sum[WIDTH-1] != in1[WIDTH-1]);
  assign diff_ovf = (in1[WIDTH-1] != in2[WIDTH-1]) && (diff[WIDTH-1] != in1[WIDTH-1]);

  // SLT uses a true signed compare so it stays correct when the subtraction overflows.
  always_comb begin
    result = '0;
    ovf    = 1'b0;
    case (aluctrl)
      CTRL_AND: result = in1 & in2;
      CTRL_OR:  result = in1 | in2;
      CTRL_ADD: begin
        result = sum;
        ovf    = sum_ovf;
      end
      CTRL_SUB: begin
        result = diff;
        ovf    = diff_ovf;
      end
      CTRL_SLT: result = ($signed(in1) < $signed(in2)) ? WIDTH'(1) : '0;
      CTRL_NOR: result = ~(in1 | in2);
      default:  result = '0;
    endcase
  end

  assign zero     = (result == '0);
  assign pc_plus4 = pc + WIDTH'(4);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      result_q <= '0;
      zero_q   <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      result_q <= result;
      zero_q   <= zero;
      ovf_q    <= ovf;
    end
  end

endmodule

// File: tb/tb_alu_exec_unit.sv
// Self-checking bench for alu_exec_unit: directed vectors with constant expectations plus
// random vectors scored against an independent reference model through an expectation queue.
module tb_alu_exec_unit;

  typedef struct {
    logic [3:0]  ctrl;
    logic [31:0] res;
    logic        z;
    logic        o;
    logic [31:0] pcn;
  } exp_t;

  logic        clk;
  logic        rst;
  logic [31:0] in1;
  logic [31:0] in2;
  logic [5:0]  func;
  logic [1:0]  aluop;
  logic [31:0] pc;
  logic [3:0]  aluctrl;
  logic [31:0] result;
  logic        zero;
  logic        ovf;
  logic [31:0] pc_plus4;
  logic [31:0] result_q;
  logic        zero_q;
  logic        ovf_q;

  int   n_checks;
  int   n_errors;
  exp_t sb[$];

  alu_exec_unit #(.WIDTH(32)) dut (
    .clk      (clk),
    .rst      (rst),
    .in1      (in1),
    .in2      (in2),
    .func     (func),
    .aluop    (aluop),
    .pc       (pc),
    .aluctrl  (aluctrl),
    .result   (result),
    .zero     (zero),
    .ovf      (ovf),
    .pc_plus4 (pc_plus4),
    .result_q (result_q),
    .zero_q   (zero_q),
    .ovf_q    (ovf_q)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  // Reference model written from the operation table, not from the RTL structure.
  function automatic exp_t model(input logic [1:0] op, input logic [5:0] f,
                                 input logic [31:0] a, input logic [31:0] b,
                                 input logic [31:0] p);
    exp_t e;
    logic [32:0] wide;
    e.o = 1'b0;
    if (op == 2'b00)      e.ctrl = 4'b0010;
    else if (op == 2'b01) e.ctrl = 4'b0110;
    else if (op == 2'b11) e.ctrl = 4'b0001;
    else if (f == 6'b100010) e.ctrl = 4'b0110;
    else if (f == 6'b100100) e.ctrl = 4'b0000;
    else if (f == 6'b100101) e.ctrl = 4'b0001;
    else if (f == 6'b100111) e.ctrl = 4'b1100;
    else if (f == 6'b101010) e.ctrl = 4'b0111;
    else e.ctrl = 4'b0010;
    case (e.ctrl)
      4'b0000: e.res = a & b;
      4'b0001: e.res = a | b;
      4'b1100: e.res = ~a & ~b;
      4'b0111: e.res = {31'd0, (a ^ 32'h8000_0000) < (b ^ 32'h8000_0000)};
      4'b0110: begin
        wide  = {a[31], a} - {b[31], b};
        e.res = wide[31:0];
        e.o   = wide[32] ^ wide[31];
      end
      default: begin
        wide  = {a[31], a} + {b[31], b};
        e.res = wide[31:0];
        e.o   = wide[32] ^ wide[31];
      end
    endcase
    e.z   = (e.res == 32'd0);
    e.pcn = p + 32'd4;
    return e;
  endfunction

  // Drive one vector between edges, queue its expectation, check the combinational
  // outputs, then check the registered copy one edge later.
  task automatic drive(input logic [1:0] op, input logic [5:0] f,
                       input logic [31:0] a, input logic [31:0] b, input logic [31:0] p,
                       input exp_t e, input string tag);
    exp_t got;
    @(negedge clk);
    aluop = op; func = f; in1 = a; in2 = b; pc = p;
    sb.push_back(e);
    #1;
    got = sb.pop_front();
    check({tag, ".ctrl"}, {28'd0, aluctrl}, {28'd0, got.ctrl});
    check({tag, ".res"},  result, got.res);
    check({tag, ".zero"}, {31'd0, zero}, {31'd0, got.z});
    check({tag, ".ovf"},  {31'd0, ovf}, {31'd0, got.o});
    check({tag, ".pc4"},  pc_plus4, got.pcn);
    @(posedge clk);
    #1;
    check({tag, ".res_q"},  result_q, got.res);
    check({tag, ".zero_q"}, {31'd0, zero_q}, {31'd0, got.z});
    check({tag, ".ovf_q"},  {31'd0, ovf_q}, {31'd0, got.o});
  endtask

  function automatic exp_t mk(input logic [3:0] c, input logic [31:0] r,
                              input logic z, input logic o, input logic [31:0] pn);
    exp_t e;
    e.ctrl = c; e.res = r; e.z = z; e.o = o; e.pcn = pn;
    return e;
  endfunction

  initial begin
    logic [1:0]  rop;
    logic [5:0]  rf;
    logic [31:0] ra, rb, rp;
    logic [5:0]  fl [6];
    fl[0] = 6'b100000; fl[1] = 6'b100010; fl[2] = 6'b100100;
    fl[3] = 6'b100101; fl[4] = 6'b100111; fl[5] = 6'b101010;
    n_checks = 0;
    n_errors = 0;

    rst = 1'b0; aluop = 2'b00; func = 6'd0; in1 = 32'd0; in2 = 32'd0; pc = 32'd0;
    #1;
    check("rst.res_q",  result_q, 32'd0);
    check("rst.zero_q", {31'd0, zero_q}, 32'd0);
    @(posedge clk);
    #1;
    check("rst_hold.zero_q", {31'd0, zero_q}, 32'd0);
    check("rst_hold.ovf_q",  {31'd0, ovf_q}, 32'd0);
    @(negedge clk);
    rst = 1'b1;

    // ALU-control decode, a=12 b=10
    drive(2'b10, 6'b100000, 32'd12, 32'd10, 32'h0000_3000, mk(4'b0010, 32'h16, 0, 0, 32'h0000_3004), "r_add");
    drive(2'b10, 6'b100010, 32'd12, 32'd10, 32'hFFFF_FFFC, mk(4'b0110, 32'h2, 0, 0, 32'h0000_0000), "r_sub");
    drive(2'b10, 6'b100100, 32'd12, 32'd10, 32'h0, mk(4'b0000, 32'h8, 0, 0, 32'h4), "r_and");
    drive(2'b10, 6'b100101, 32'd12, 32'd10, 32'h0, mk(4'b0001, 32'hE, 0, 0, 32'h4), "r_or");
    drive(2'b10, 6'b100111, 32'd12, 32'd10, 32'h0, mk(4'b1100, 32'hFFFF_FFF1, 0, 0, 32'h4), "r_nor");
    drive(2'b10, 6'b101010, 32'd12, 32'd10, 32'h0, mk(4'b0111, 32'h0, 1, 0, 32'h4), "r_slt");
    drive(2'b10, 6'b000000, 32'd12, 32'd10, 32'h0, mk(4'b0010, 32'h16, 0, 0, 32'h4), "r_dflt");
    drive(2'b00, 6'b100100, 32'd12, 32'd10, 32'h0, mk(4'b0010, 32'h16, 0, 0, 32'h4), "op00");
    drive(2'b01, 6'b100101, 32'd12, 32'd10, 32'h0, mk(4'b0110, 32'h2, 0, 0, 32'h4), "op01");
    drive(2'b11, 6'b100000, 32'd12, 32'd10, 32'h0, mk(4'b0001, 32'hE, 0, 0, 32'h4), "op11");

    // Arithmetic and comparison boundaries
    drive(2'b00, 6'd0, 32'h7FFF_FFFF, 32'd1, 32'h10, mk(4'b0010, 32'h8000_0000, 0, 1, 32'h14), "add_ovf");
    drive(2'b00, 6'd0, 32'hFFFF_FFFF, 32'd1, 32'h10, mk(4'b0010, 32'h0, 1, 0, 32'h14), "add_wrap");
    drive(2'b01, 6'd0, 32'd5, 32'd5, 32'h10, mk(4'b0110, 32'h0, 1, 0, 32'h14), "sub_eq");
    drive(2'b01, 6'd0, 32'h8000_0000, 32'd1, 32'h10, mk(4'b0110, 32'h7FFF_FFFF, 0, 1, 32'h14), "sub_ovf");
    drive(2'b10, 6'b101010, 32'hFFFF_FFFF, 32'd1, 32'h10, mk(4'b0111, 32'd1, 0, 0, 32'h14), "slt_neg");
    drive(2'b10, 6'b101010, 32'd1, 32'hFFFF_FFFF, 32'h10, mk(4'b0111, 32'd0, 1, 0, 32'h14), "slt_pos");
    drive(2'b10, 6'b101010, 32'h8000_0000, 32'h7FFF_FFFF, 32'h10, mk(4'b0111, 32'd1, 0, 0, 32'h14), "slt_ext");

    for (int i = 0; i < 40; i++) begin
      rop = 2'($urandom_range(0, 3));
      rf  = ($urandom_range(0, 3) == 0) ? 6'($urandom_range(0, 63)) : fl[$urandom_range(0, 5)];
      ra  = $urandom;
      rb  = ($urandom_range(0, 4) == 0) ? ra : $urandom;
      rp  = {$urandom_range(0, 32'h3FFF_FFFF), 2'b00};
      drive(rop, rf, ra, rb, rp, model(rop, rf, ra, rb, rp), "rand");
    end

    // Reset asserted mid-cycle after capturing ADD 2+3
    drive(2'b00, 6'd0, 32'd2, 32'd3, 32'h100, mk(4'b0010, 32'd5, 0, 0, 32'h104), "pre_rst");
    #2;
    rst = 1'b0;
    #1;
    check("arst.res_q",  result_q, 32'd0);
    check("arst.zero_q", {31'd0, zero_q}, 32'd0);
    check("arst.comb",   result, 32'd5);
    repeat (2) @(posedge clk);
    #1;
    check("arst_hold.res_q", result_q, 32'd0);
    check("arst_hold.zero_q", {31'd0, zero_q}, 32'd0);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    check("rst_rel.res_q", result_q, 32'd5);
    check("rst_rel.zero_q", {31'd0, zero_q}, 32'd0);

    check("sb_empty", 32'(sb.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
